// File: rtl/spi_adar7251_pkg.sv
// Shared types and constants for the ADAR7251 burst SPI master.
package spi_adar7251_pkg;

    localparam int   HDR_W    = 8;
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_CS_GAP
    } state_t;

    typedef enum logic [1:0] {
        PH_HDR,
        PH_ADDR,
        PH_DATA
    } phase_t;

endpackage

// File: rtl/spi_adar7251_burst_sclk_gen.sv
// SCLK generator: half-period down-counter, toggles SCLK at terminal count.
// o_rise/o_fall flag the i_clk edge at which SCLK changes level.
module spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int               CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             toggle;

    always_comb begin
        toggle = i_en && (cnt_q == '0);
        cnt_d  = '0;
        sclk_d = 1'b0;
        if (i_en) begin
            sclk_d = sclk_q;
            if (toggle) begin
                cnt_d  = CNT_RELOAD;
                sclk_d = ~sclk_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign o_sclk = sclk_q;
    assign o_rise = toggle && !sclk_q;
    assign o_fall = toggle && sclk_q;

endmodule

// File: rtl/spi_adar7251_burst.sv
// SPI master for the ADAR7251 register port: header, address, then 1..MAX_BURST data words.
// Burst length and i_abort are honoured only when SPI_ADAR7251_BURST_EN is defined.
//
// state       | meaning
// ST_IDLE     | CSB high, waiting for i_enable
// ST_CS_SETUP | CSB low, SCLK low, CLK_DIV cycles before first rise
// ST_SHIFT    | SCLK running, one bit per SCLK period
// ST_CS_HOLD  | SCLK low, CSB still low for CLK_DIV cycles
// ST_CS_GAP   | CSB high for CLK_DIV cycles, then o_finish
module spi_adar7251_burst
    import spi_adar7251_pkg::*;
#(
    parameter int         CLK_DIV   = 2,
    parameter logic [6:0] CHIP_ADDR = 7'h00,
    parameter int         ADDR_W    = 16,
    parameter int         DATA_W    = 16,
    parameter int         MAX_BURST = 16,
    parameter int         BURST_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_reg_rd_wrb,
    input  logic [ADDR_W-1:0]  i_reg_addr,
    input  logic [BURST_W-1:0] i_burst_len,
    input  logic [DATA_W-1:0]  i_reg_data,
    input  logic               i_abort,
    input  logic               i_SPI_SDI,
    output logic               o_SPI_SDO,
    output logic               o_SPI_SCLK,
    output logic               o_SPI_CSB,
    output logic               o_SPI_DIR,
    output logic [DATA_W-1:0]  o_reg_data,
    output logic               o_data_req,
    output logic               o_data_valid,
    output logic               o_busy,
    output logic               o_finish
);

    localparam int               TX_W       = HDR_W + ADDR_W + DATA_W;
    localparam int               TMR_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(CLK_DIV - 1);
    localparam int               FLD_MAX    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int               FLD_W      = $clog2(FLD_MAX);

    state_t              state_q, state_d;
    phase_t              phase_q, phase_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [FLD_W-1:0]    fld_q, fld_d;
    logic [BURST_W-1:0]  words_left_q, words_left_d;
    logic                rd_q, rd_d;
    logic                abort_q, abort_d;
    logic [TX_W-1:0]     shreg_q, shreg_d;
    logic [DATA_W-1:0]   next_word_q, next_word_d;
    logic                req_dly_q, req_dly_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   reg_data_q, reg_data_d;
    logic                data_req_q, data_req_d;
    logic                data_valid_q, data_valid_d;
    logic                finish_q, finish_d;
    logic                dir_q, dir_d;

    logic                sclk_en, sclk, sclk_rise, sclk_fall;
    logic                end_frame, abort_now;
    logic [BURST_W-1:0]  burst_len_in;
    logic                abort_in;

`ifdef SPI_ADAR7251_BURST_EN
    assign burst_len_in = i_burst_len;
    assign abort_in     = i_abort;
`else
    logic unused_burst_ctrl;
    assign unused_burst_ctrl = ^{i_burst_len, i_abort};
    assign burst_len_in      = '0;
    assign abort_in          = 1'b0;
`endif

    // Enabled one cycle early so the first rise lands on the SETUP->SHIFT edge.
    assign sclk_en = (state_q == ST_SHIFT) || ((state_q == ST_CS_SETUP) && (tmr_q == '0));

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (sclk_en),
        .o_sclk  (sclk),
        .o_rise  (sclk_rise),
        .o_fall  (sclk_fall)
    );

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        tmr_d        = tmr_q;
        fld_d        = fld_q;
        words_left_d = words_left_q;
        rd_d         = rd_q;
        abort_d      = abort_q;
        shreg_d      = shreg_q;
        next_word_d  = next_word_q;
        req_dly_d    = data_req_q;
        rx_d         = rx_q;
        reg_data_d   = reg_data_q;
        data_req_d   = 1'b0;
        data_valid_d = 1'b0;
        finish_d     = 1'b0;
        dir_d        = dir_q;
        end_frame    = 1'b0;
        abort_now    = abort_q || abort_in;

        if (req_dly_q) begin
            next_word_d = i_reg_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d      = ST_CS_SETUP;
                    tmr_d        = TMR_RELOAD;
                    phase_d      = PH_HDR;
                    fld_d        = FLD_W'(HDR_W - 1);
                    words_left_d = burst_len_in;
                    rd_d         = i_reg_rd_wrb;
                    abort_d      = 1'b0;
                    rx_d         = '0;
                    dir_d        = 1'b1;
                    shreg_d      = {CHIP_ADDR, i_reg_rd_wrb, i_reg_addr,
                                    (i_reg_rd_wrb == RW_READ) ? {DATA_W{1'b0}} : i_reg_data};
                end
            end
            ST_CS_SETUP: begin
                if (tmr_q == '0) begin
                    state_d = ST_SHIFT;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_SHIFT: begin
                abort_d = abort_now;
                if (sclk_rise && (phase_q == PH_DATA) && (rd_q == RW_READ)) begin
                    rx_d = {rx_q[DATA_W-2:0], i_SPI_SDI};
                end
                if (sclk_fall) begin
                    shreg_d = shreg_q << 1;
                    if ((phase_q == PH_DATA) && (rd_q == RW_READ) && (fld_q == '0)) begin
                        reg_data_d   = rx_q;
                        data_valid_d = 1'b1;
                    end
                    if (fld_q == '0) begin
                        case (phase_q)
                            PH_HDR: begin
                                phase_d = PH_ADDR;
                                fld_d   = FLD_W'(ADDR_W - 1);
                            end
                            PH_ADDR: begin
                                if (abort_now) begin
                                    end_frame = 1'b1;
                                end else begin
                                    phase_d = PH_DATA;
                                    fld_d   = FLD_W'(DATA_W - 1);
                                    dir_d   = (rd_q != RW_READ);
                                end
                            end
                            default: begin
                                if (abort_now || (words_left_q == '0)) begin
                                    end_frame = 1'b1;
                                end else begin
                                    words_left_d = words_left_q - 1'b1;
                                    fld_d        = FLD_W'(DATA_W - 1);
                                    if (rd_q == RW_WRITE) begin
                                        shreg_d = {next_word_q, {(TX_W-DATA_W){1'b0}}};
                                    end
                                end
                            end
                        endcase
                    end else begin
                        fld_d = fld_q - 1'b1;
                        // This fall launches the last bit of a word that has a successor.
                        if ((phase_q == PH_DATA) && (fld_q == FLD_W'(1)) && (words_left_q != '0)
                            && (rd_q == RW_WRITE) && !abort_now) begin
                            data_req_d = 1'b1;
                        end
                    end
                    if (end_frame) begin
                        state_d = ST_CS_HOLD;
                        tmr_d   = TMR_RELOAD;
                        dir_d   = 1'b1;
                        shreg_d = '0;
                    end
                end
            end
            ST_CS_HOLD: begin
                if (tmr_q == '0) begin
                    state_d = ST_CS_GAP;
                    tmr_d   = TMR_RELOAD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_CS_GAP: begin
                if (tmr_q == '0) begin
                    state_d  = ST_IDLE;
                    finish_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            phase_q      <= PH_HDR;
            tmr_q        <= '0;
            fld_q        <= '0;
            words_left_q <= '0;
            rd_q         <= 1'b0;
            abort_q      <= 1'b0;
            shreg_q      <= '0;
            next_word_q  <= '0;
            req_dly_q    <= 1'b0;
            rx_q         <= '0;
            reg_data_q   <= '0;
            data_req_q   <= 1'b0;
            data_valid_q <= 1'b0;
            finish_q     <= 1'b0;
            dir_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            tmr_q        <= tmr_d;
            fld_q        <= fld_d;
            words_left_q <= words_left_d;
            rd_q         <= rd_d;
            abort_q      <= abort_d;
            shreg_q      <= shreg_d;
            next_word_q  <= next_word_d;
            req_dly_q    <= req_dly_d;
            rx_q         <= rx_d;
            reg_data_q   <= reg_data_d;
            data_req_q   <= data_req_d;
            data_valid_q <= data_valid_d;
            finish_q     <= finish_d;
            dir_q        <= dir_d;
        end
    end

    assign o_SPI_SDO    = shreg_q[TX_W-1];
    assign o_SPI_SCLK   = sclk;
    assign o_SPI_CSB    = (state_q == ST_IDLE) || (state_q == ST_CS_GAP);
    assign o_SPI_DIR    = dir_q;
    assign o_reg_data   = reg_data_q;
    assign o_data_req   = data_req_q;
    assign o_data_valid = data_valid_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_finish     = finish_q;

endmodule

// File: tb/tb_spi_adar7251_burst.sv
// Table-driven bench for spi_adar7251_burst with a behavioural SPI device model.
module tb_spi_adar7251_burst;

    localparam int CLK_DIV = 2;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int BURST_W = 4;
`ifdef SPI_ADAR7251_BURST_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               i_reset = 1'b1;
    logic               i_enable = 1'b0;
    logic               i_reg_rd_wrb = 1'b0;
    logic [ADDR_W-1:0]  i_reg_addr = '0;
    logic [BURST_W-1:0] i_burst_len = '0;
    logic [DATA_W-1:0]  i_reg_data = '0;
    logic               i_abort = 1'b0;
    logic               i_SPI_SDI = 1'b0;
    logic               o_SPI_SDO, o_SPI_SCLK, o_SPI_CSB, o_SPI_DIR;
    logic [DATA_W-1:0]  o_reg_data;
    logic               o_data_req, o_data_valid, o_busy, o_finish;

    always #5 clk = ~clk;

    spi_adar7251_burst #(
        .CLK_DIV(CLK_DIV), .CHIP_ADDR(7'h00), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .MAX_BURST(16), .BURST_W(BURST_W)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable),
        .i_reg_rd_wrb(i_reg_rd_wrb), .i_reg_addr(i_reg_addr),
        .i_burst_len(i_burst_len), .i_reg_data(i_reg_data), .i_abort(i_abort),
        .i_SPI_SDI(i_SPI_SDI), .o_SPI_SDO(o_SPI_SDO), .o_SPI_SCLK(o_SPI_SCLK),
        .o_SPI_CSB(o_SPI_CSB), .o_SPI_DIR(o_SPI_DIR), .o_reg_data(o_reg_data),
        .o_data_req(o_data_req), .o_data_valid(o_data_valid),
        .o_busy(o_busy), .o_finish(o_finish)
    );

    typedef struct {
        logic            rd;
        logic [15:0]     addr;
        logic [3:0]      len;
        logic [3:0][15:0] wr;
        logic [3:0][15:0] rdw;
        int              abort_cyc;  // 0 = no abort
        int              stray_cyc;  // 0 = no enable while busy
        int              nw_burst;   // words actually framed when bursts are enabled
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    function automatic logic sdi_bit(input vec_t v, input int idx);
        int w, b;
        if (idx < 24) return 1'b0;
        w = (idx - 24) / 16;
        b = 15 - ((idx - 24) % 16);
        if (w > 3) return 1'b0;
        return v.rdw[w][b];
    endfunction

    task automatic run_vec(input vec_t v, input int id, input bit no_wait, input bit chain);
        int nw, f, rises, dir0, reqs, valids, fin_cyc, csbh_cyc, csbl_cyc, wr_idx;
        logic [127:0] sdo_cap, exp_sdo;
        logic prev_sclk, prev_csb;
        bit done;
        string tag;
        tag = $sformatf("v%0d", id);
        nw = BURST_ON ? v.nw_burst : 1;
        f  = 24 + 16 * nw;
        exp_sdo = {104'd0, 7'h00, v.rd, v.addr};
        for (int k = 0; k < nw; k++) exp_sdo = (exp_sdo << 16) | (v.rd ? 128'd0 : {112'd0, v.wr[k]});
        rises = 0; dir0 = 0; reqs = 0; valids = 0; fin_cyc = -1; csbh_cyc = -1; csbl_cyc = -1;
        wr_idx = 0; sdo_cap = '0; prev_sclk = 1'b0; prev_csb = 1'b1; done = 1'b0;

        if (!no_wait) @(negedge clk);
        i_reg_rd_wrb = v.rd;
        i_reg_addr   = v.addr;
        i_burst_len  = v.len;
        i_reg_data   = v.wr[0];
        i_enable     = 1'b1;
        for (int c = 1; c <= 2000 && !done; c++) begin
            @(negedge clk);
            i_enable = (c == v.stray_cyc);
            if (c == v.stray_cyc) begin
                i_reg_addr   = 16'hDEAD;
                i_reg_rd_wrb = ~v.rd;
            end
            i_abort = (c == v.abort_cyc);
            if (!o_SPI_CSB && prev_csb && csbl_cyc < 0) csbl_cyc = c;
            if (o_SPI_CSB && !prev_csb) csbh_cyc = c;
            if (o_SPI_SCLK && !prev_sclk) begin
                sdo_cap = {sdo_cap[126:0], o_SPI_SDO};
                rises++;
                if (!o_SPI_DIR) dir0++;
            end
            if (o_data_req) begin
                reqs++;
                if (wr_idx < 3) wr_idx++;
                i_reg_data = v.wr[wr_idx];
            end
            if (o_data_valid) begin
                check({tag, "_rdata"}, o_reg_data, v.rdw[valids[1:0]]);
                valids++;
            end
            if (o_finish) begin
                fin_cyc = c;
                done = 1'b1;
                check({tag, "_busy_at_finish"}, o_busy, 1'b0);
                check({tag, "_dir_at_finish"}, o_SPI_DIR, 1'b1);
            end
            if ((prev_sclk && !o_SPI_SCLK) || (!o_SPI_CSB && prev_csb)) i_SPI_SDI = sdi_bit(v, rises);
            prev_sclk = o_SPI_SCLK;
            prev_csb  = o_SPI_CSB;
        end
        i_enable = 1'b0;
        i_abort  = 1'b0;
        check({tag, "_finish_seen"}, done, 1'b1);
        check({tag, "_csb_low_cyc"}, csbl_cyc, 1);
        check({tag, "_bits"}, rises, f);
        if (v.rd) check({tag, "_sdo_hdr_addr"}, sdo_cap >> (16 * nw), {104'd0, 7'h00, v.rd, v.addr});
        else      check({tag, "_sdo_stream"}, sdo_cap, exp_sdo);
        check({tag, "_csb_high_cyc"}, csbh_cyc, 1 + CLK_DIV * (2 * f + 1));
        check({tag, "_finish_cyc"}, fin_cyc, 1 + CLK_DIV * (2 * f + 2));
        check({tag, "_dir0_bits"}, dir0, v.rd ? 16 * nw : 0);
        check({tag, "_data_req"}, reqs, (!v.rd && nw > 1) ? nw - 1 : 0);
        check({tag, "_data_valid"}, valids, v.rd ? nw : 0);
        if (!chain) begin
            repeat (3) @(negedge clk);
            check({tag, "_idle_after"}, {o_busy, o_SPI_CSB, o_SPI_SCLK}, 3'b010);
        end
    endtask

    vec_t vecs[7];
    vec_t w0;

    initial begin
        int fin_seen;
        vecs[0] = '{rd:1'b0, addr:16'h0505, len:4'd0, wr:{16'h0, 16'h0, 16'h0, 16'hAAAA},
                    rdw:'0, abort_cyc:0, stray_cyc:0, nw_burst:1};
        vecs[1] = '{rd:1'b1, addr:16'h0505, len:4'd0, wr:'0,
                    rdw:{16'h0, 16'h0, 16'h0, 16'h1234}, abort_cyc:0, stray_cyc:0, nw_burst:1};
        vecs[2] = '{rd:1'b0, addr:16'h0010, len:4'd2, wr:{16'h0, 16'h3333, 16'h2222, 16'h1111},
                    rdw:'0, abort_cyc:0, stray_cyc:0, nw_burst:3};
        vecs[3] = '{rd:1'b1, addr:16'h0505, len:4'd3, wr:'0,
                    rdw:{16'h0F0F, 16'h5A5A, 16'hCAFE, 16'hBEEF}, abort_cyc:180, stray_cyc:0, nw_burst:2};
        vecs[4] = '{rd:1'b0, addr:16'h4321, len:4'd1, wr:{16'h0, 16'h0, 16'h2222, 16'h1111},
                    rdw:'0, abort_cyc:10, stray_cyc:0, nw_burst:0};
        vecs[5] = '{rd:1'b0, addr:16'hFFFF, len:4'd0, wr:{16'h0, 16'h0, 16'h0, 16'h8001},
                    rdw:'0, abort_cyc:0, stray_cyc:50, nw_burst:1};
        vecs[6] = '{rd:1'b1, addr:16'h00FF, len:4'd1, wr:'0,
                    rdw:{16'h0, 16'h0, 16'h7FFE, 16'h8001}, abort_cyc:0, stray_cyc:0, nw_burst:2};
        w0 = vecs[0];

        i_reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {o_SPI_SDO, o_SPI_SCLK, o_SPI_CSB, o_SPI_DIR,
                             o_data_req, o_data_valid, o_busy, o_finish}, 8'b0011_0000);
        check("reset_reg_data", o_reg_data, 16'h0000);
        i_reset = 1'b0;

        // vec 0 ends in its o_finish cycle so vec 1 is launched in that same cycle.
        for (int i = 0; i < 7; i++) run_vec(vecs[i], i, (i == 1), (i == 0));

        // Reset in the middle of SHIFT abandons the frame without o_finish.
        @(negedge clk);
        i_reg_rd_wrb = 1'b0; i_reg_addr = 16'h0505; i_reg_data = 16'hAAAA; i_burst_len = '0;
        i_enable = 1'b1;
        @(negedge clk);
        i_enable = 1'b0;
        repeat (59) @(negedge clk);
        check("mid_busy", o_busy, 1'b1);
        i_reset = 1'b1;
        @(negedge clk);
        check("rst_ctrl", {o_SPI_SDO, o_SPI_SCLK, o_SPI_CSB, o_SPI_DIR,
                           o_data_req, o_data_valid, o_busy, o_finish}, 8'b0011_0000);
        check("rst_reg_data", o_reg_data, 16'h0000);
        i_reset = 1'b0;
        fin_seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (o_finish || o_busy || !o_SPI_CSB) fin_seen++;
        end
        check("rst_no_finish", fin_seen, 0);
        run_vec(w0, 7, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
